// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host receiver: line synchronisers, clock glitch filter, 11-bit frame
// decoder with parity/framing checks, inter-edge watchdog and a small byte FIFO.
module ps2_frame_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_parity,
  output logic                          err_frame,
  output logic                          err_timeout,
  output logic                          err_overflow
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   sclk;
  logic                   sdata;
  logic                   fclk;
  logic                   fclk_d;
  logic [FW-1:0]          filt_cnt;
  logic                   ps2_edge;

  state_t                 state;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift_reg;
  logic                   parity_bit;
  logic [WW-1:0]          wd_cnt;
  logic                   timeout_hit;
  logic                   frame_done;
  logic                   push;

  logic [7:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   full;
  logic                   pop;
  logic                   push_ok;

  assign sclk  = clk_sync[SYNC_STAGES-1];
  assign sdata = data_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // fclk follows sclk only once the new level has held for FILTER_LEN straight cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      fclk     <= 1'b1;
      fclk_d   <= 1'b1;
      filt_cnt <= '0;
    end else begin
      fclk_d <= fclk;
      if (sclk != fclk) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          fclk     <= sclk;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + FW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign ps2_edge    = fclk && !fclk_d;
  assign timeout_hit = (state != IDLE) && (wd_cnt == WW'(TIMEOUT_CYCLES));
  assign frame_done  = (state == STOP) && ps2_edge && !timeout_hit;
  assign push        = frame_done && sdata && (^{shift_reg, parity_bit});

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      parity_bit  <= 1'b0;
      wd_cnt      <= '0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      if (state == IDLE) begin
        wd_cnt <= '0;
        if (ps2_edge && !sdata) begin
          state   <= DATA;
          bit_cnt <= '0;
        end
      end else if (timeout_hit) begin
        state       <= IDLE;
        wd_cnt      <= '0;
        err_timeout <= 1'b1;
      end else begin
        wd_cnt <= ps2_edge ? '0 : wd_cnt + WW'(1);
        if (ps2_edge) begin
          case (state)
            DATA: begin
              shift_reg <= {sdata, shift_reg[7:1]};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= PARITY;
            end
            PARITY: begin
              parity_bit <= sdata;
              state      <= STOP;
            end
            STOP: begin
              state <= IDLE;
              // A bad stop bit outranks a parity error so only one pulse fires per frame
              if (!sdata) err_frame <= 1'b1;
              else if (!(^{shift_reg, parity_bit})) err_parity <= 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  assign rx_valid = (fifo_count != '0);
  assign full     = (fifo_count == CW'(FIFO_DEPTH));
  assign pop      = rx_valid && rx_ready;
  assign push_ok  = push && (!full || pop);
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      err_overflow <= 1'b0;
    end else begin
      err_overflow <= push && full && !pop;
      if (push_ok) begin
        mem[wr_ptr] <= shift_reg;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench for ps2_frame_receiver: PS/2 frames are bit-banged, expected bytes go
// through a scoreboard queue and error pulses are tallied by a monitor.
module tb_ps2_frame_receiver;

  localparam int S  = 2;
  localparam int F  = 4;
  localparam int T  = 200;
  localparam int D  = 4;
  localparam int H  = 12;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          ps2_clk;
  logic          ps2_data;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [CW-1:0] fifo_count;
  logic          err_parity;
  logic          err_frame;
  logic          err_timeout;
  logic          err_overflow;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         model_count = 0;
  int         exp_par = 0, exp_frame = 0, exp_to = 0, exp_ovf = 0;
  int         n_par = 0, n_frame = 0, n_to = 0, n_ovf = 0;
  int         long_pulses = 0, multi_err = 0;
  logic [3:0] prev_err = '0;
  logic [3:0] errs;
  int         lat;
  int         n;

  ps2_frame_receiver #(
    .SYNC_STAGES(S), .FILTER_LEN(F), .TIMEOUT_CYCLES(T), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .fifo_count(fifo_count),
    .err_parity(err_parity), .err_frame(err_frame), .err_timeout(err_timeout),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  // Every high sample of an error line counts once; stretched or overlapping pulses are noted
  always @(negedge clk) begin
    errs = {err_parity, err_frame, err_timeout, err_overflow};
    if (!rst) begin
      n_par   += int'(err_parity);
      n_frame += int'(err_frame);
      n_to    += int'(err_timeout);
      n_ovf   += int'(err_overflow);
      if ((errs & prev_err) != 4'b0) long_pulses++;
      if ($countones(errs) > 1) multi_err++;
    end
    prev_err = errs;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_errs(input string step);
    #1;
    check_output({step, "/err_parity"},   n_par,   exp_par);
    check_output({step, "/err_frame"},    n_frame, exp_frame);
    check_output({step, "/err_timeout"},  n_to,    exp_to);
    check_output({step, "/err_overflow"}, n_ovf,   exp_ovf);
  endtask

  // One PS/2 bit: high phase, falling edge with new data, low phase, then the rise; optional glitches
  task automatic ps2_bit(input logic b, input int g);
    repeat (H) @(negedge clk);
    if (g > 0) begin
      ps2_clk = 1'b0;
      repeat (g) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (H) @(negedge clk);
    end
    ps2_clk  = 1'b0;
    ps2_data = b;
    repeat (H) @(negedge clk);
    if (g > 0) begin
      ps2_clk = 1'b1;
      repeat (g) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (H) @(negedge clk);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic apply_stimulus(input logic [7:0] data, input bit par_ok, input bit stop_ok,
                                input int glitch, input int pop_at, output int latency);
    logic [10:0] frame;
    logic        par;
    logic        was_valid;
    par = ~^data;
    if (!par_ok) par = ~par;
    frame = {stop_ok, par, data, 1'b0};
    if (!stop_ok) exp_frame++;
    else if (!par_ok) exp_par++;
    else if (pop_at > 0) exp_q.push_back(data);
    else if (model_count < D) begin
      exp_q.push_back(data);
      model_count++;
    end else exp_ovf++;
    for (int i = 0; i < 11; i++) ps2_bit(frame[i], (i >= 2 && i <= 8) ? glitch : 0);
    was_valid = rx_valid;
    latency   = -1;
    for (int k = 1; k <= H; k++) begin
      @(negedge clk);
      if (latency < 0 && rx_valid && !was_valid) latency = k;
      if (pop_at > 0) begin
        if (k == pop_at) begin
          check_output("pop_head_data", rx_data, exp_q.pop_front());
          rx_ready = 1'b1;
        end else begin
          rx_ready = 1'b0;
        end
      end
    end
    ps2_data = 1'b1;
  endtask

  task automatic drain(input int n_expected, input string step);
    int         got;
    logic [7:0] e;
    got = 0;
    for (int i = 0; i < D + 2; i++) begin
      @(negedge clk);
      rx_ready = 1'b0;
      if (!rx_valid) break;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hEE;
      check_output({step, "/drain_data"}, rx_data, e);
      rx_ready = 1'b1;
      got++;
      model_count--;
    end
    rx_ready = 1'b0;
    check_output({step, "/drain_count"}, got, n_expected);
    check_output({step, "/empty_valid"}, rx_valid, 1'b0);
    check_output({step, "/empty_data"}, rx_data, 8'h00);
    check_output({step, "/empty_count"}, fifo_count, 0);
  endtask

  initial begin
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset/rx_valid", rx_valid, 1'b0);
    check_output("reset/rx_data", rx_data, 8'h00);
    check_output("reset/fifo_count", fifo_count, 0);
    check_output("reset/errs", {err_parity, err_frame, err_timeout, err_overflow}, 4'b0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    apply_stimulus(8'h1C, 1, 1, 0, 0, lat);
    check_output("good/valid_latency", lat, S + F + 1);
    check_output("good/rx_data", rx_data, 8'h1C);
    check_output("good/fifo_count", fifo_count, 1);
    check_errs("good");
    drain(1, "good");

    apply_stimulus(8'hF0, 0, 1, 0, 0, lat);
    check_output("parity/fifo_count", fifo_count, 0);
    check_errs("parity");
    apply_stimulus(8'hF0, 1, 0, 0, 0, lat);
    check_output("frame/fifo_count", fifo_count, 0);
    check_errs("frame");

    for (int g = 1; g < F; g++) apply_stimulus(8'h5A, 1, 1, g, 0, lat);
    check_output("glitch/fifo_count", fifo_count, F - 1);
    check_errs("glitch");
    drain(F - 1, "glitch");

    ps2_bit(1'b0, 0);
    ps2_bit(1'b1, 0);
    ps2_bit(1'b0, 0);
    ps2_bit(1'b1, 0);
    exp_to++;
    n = 0;
    while (n <= 2 * T) begin
      @(negedge clk);
      n++;
      if (err_timeout) break;
    end
    check_output("timeout/latency", n, S + F + T + 2);
    @(negedge clk);
    check_output("timeout/single_cycle", err_timeout, 1'b0);
    ps2_data = 1'b1;
    check_errs("timeout");
    apply_stimulus(8'h29, 1, 1, 0, 0, lat);
    check_errs("after_timeout");
    drain(1, "after_timeout");

    for (int v = 1; v <= D + 1; v++) apply_stimulus(8'(v), 1, 1, 0, 0, lat);
    check_output("overflow/fifo_count", fifo_count, D);
    check_errs("overflow");
    drain(D, "overflow");

    for (int v = 0; v < D; v++) apply_stimulus(8'h11 + 8'(v), 1, 1, 0, 0, lat);
    apply_stimulus(8'h15, 1, 1, 0, S + F, lat);
    check_output("push_pop/fifo_count", fifo_count, D);
    check_errs("push_pop");
    drain(D, "push_pop");

    apply_stimulus(8'h33, 1, 1, 0, 0, lat);
    apply_stimulus(8'h44, 1, 1, 0, 0, lat);
    check_output("pre_reset/fifo_count", fifo_count, 2);
    ps2_bit(1'b0, 0);
    ps2_bit(1'b1, 0);
    ps2_bit(1'b1, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("mid_reset/rx_valid", rx_valid, 1'b0);
    check_output("mid_reset/rx_data", rx_data, 8'h00);
    check_output("mid_reset/fifo_count", fifo_count, 0);
    check_output("mid_reset/errs", {err_parity, err_frame, err_timeout, err_overflow}, 4'b0);
    rst = 1'b0;
    exp_q.delete();
    model_count = 0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
    apply_stimulus(8'h77, 1, 1, 0, 0, lat);
    drain(1, "after_reset");
    repeat (2 * T) @(negedge clk);
    check_errs("final");
    check_output("final/long_pulses", long_pulses, 0);
    check_output("final/multi_error_cycles", multi_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
